// File: rtl/rc_adder.sv
// rc_adder: registered ripple-carry adder for the CPU datapath.
// The sum is formed by a chain of WIDTH full-adder cells with no lookahead
// and is captured in the output register on the clock edge where in_valid is high.
// Optional build macro RCADDER_FLAGS_EN adds registered Zero and Ovf flag outputs.

module rc_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module rc_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
`ifdef RCADDER_FLAGS_EN
  output logic             Zero,
  output logic             Ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    rc_adder_fa u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Capture the rippled sum and carry when operands are valid; otherwise hold them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Result    <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Result <= s;
        Cout   <= c[WIDTH];
      end
    end
  end

`ifdef RCADDER_FLAGS_EN
  // Zero and signed-overflow flags track the same capture rule as Result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Zero <= 1'b0;
      Ovf  <= 1'b0;
    end else if (in_valid) begin
      Zero <= (s == '0);
      Ovf  <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_rc_adder.sv
// tb_rc_adder: self-checking bench for rc_adder (WIDTH=8).
// Expected values come from plain integer arithmetic on the operands.
// Define RCADDER_FLAGS_EN to also check the Zero and Ovf outputs.

module tb_rc_adder;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         in_valid;
  logic [W-1:0] Result;
  logic         Cout;
  logic         out_valid;
`ifdef RCADDER_FLAGS_EN
  logic         Zero;
  logic         Ovf;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state: last captured sum
  logic [W-1:0] exp_res;
  logic         exp_cout;
  logic         exp_valid;
  logic         exp_zero;
  logic         exp_ovf;

  rc_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .Result    (Result),
    .Cout      (Cout),
`ifdef RCADDER_FLAGS_EN
    .Zero      (Zero),
    .Ovf       (Ovf),
`endif
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    exp_res   = '0;
    exp_cout  = 1'b0;
    exp_valid = 1'b0;
    exp_zero  = 1'b0;
    exp_ovf   = 1'b0;
  endfunction

  function automatic void model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic v);
    int unsigned usum;
    int          ssum;
    exp_valid = v;
    if (v) begin
      usum     = int'(a) + int'(b) + int'(cin);
      exp_res  = usum[W-1:0];
      exp_cout = usum[W];
      ssum     = int'($signed(a)) + int'($signed(b)) + int'(cin);
      exp_ovf  = (ssum > (2**(W-1)) - 1) || (ssum < -(2**(W-1)));
      exp_zero = (exp_res == '0);
    end
  endfunction

  // drive operands away from the edge, advance one clock, update the model
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic v);
    @(negedge clk);
    A = a; B = b; Cin = cin; in_valid = v;
    @(posedge clk);
    #1;
    model_op(a, b, cin, v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; A = '0; B = '0; Cin = 1'b0; in_valid = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    checks++; if (Result !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", Result); end
    checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", Cout); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (Result !== 8'h00) begin errors++; $display("FAIL idle_result got %h want 00", Result); end
    checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL idle_cout got %b want 0", Cout); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL idle_valid got %b want 1", out_valid); end
`ifdef RCADDER_FLAGS_EN
    checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL idle_zero got %b want 1", Zero); end
`endif
  endtask

  task automatic test_hold();
    do_op(8'h2A, 8'h3A, 1'b0, 1'b1);
    checks++; if (Result !== 8'h64) begin errors++; $display("FAIL add42_58 got %h want 64", Result); end
    checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL add42_58_cout got %b want 0", Cout); end
    for (int i = 0; i < 20; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      checks++; if (Result !== 8'h64 || out_valid !== 1'b0)
        begin errors++; $display("FAIL hold[%0d] got %h/%b want 64/0", i, Result, out_valid); end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{8'h69, 8'h69, 8'hFF, 8'hFF, 8'h7F, 8'h80};
    logic [W-1:0] tb [6] = '{8'h15, 8'h15, 8'h00, 8'hFF, 8'h01, 8'h80};
    logic         tc [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] tr [6] = '{8'h7E, 8'h7F, 8'h00, 8'hFF, 8'h80, 8'h00};
    logic         to [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], tc[i], 1'b1);
      checks++; if (Result !== tr[i]) begin errors++; $display("FAIL dir_result[%0d] got %h want %h", i, Result, tr[i]); end
      checks++; if (Cout !== to[i]) begin errors++; $display("FAIL dir_cout[%0d] got %b want %b", i, Cout, to[i]); end
`ifdef RCADDER_FLAGS_EN
      checks++; if (Ovf !== exp_ovf || Zero !== exp_zero)
        begin errors++; $display("FAIL dir_flags[%0d] got z%b o%b want z%b o%b", i, Zero, Ovf, exp_zero, exp_ovf); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] want [3] = '{8'h02, 8'h04, 8'h06};
    for (int i = 0; i < 3; i++) begin
      do_op(8'(i + 1), 8'(i + 1), 1'b0, 1'b1);
      checks++; if (Result !== want[i] || out_valid !== 1'b1)
        begin errors++; $display("FAIL b2b[%0d] got %h/%b want %h/1", i, Result, out_valid, want[i]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      checks++; if (Result !== exp_res || Cout !== exp_cout || out_valid !== exp_valid)
        begin errors++; $display("FAIL rand[%0d] got %h/%b/%b want %h/%b/%b", i,
                                 Result, Cout, out_valid, exp_res, exp_cout, exp_valid); end
`ifdef RCADDER_FLAGS_EN
      checks++; if (Zero !== exp_zero || Ovf !== exp_ovf)
        begin errors++; $display("FAIL rand_flags[%0d] got z%b o%b want z%b o%b", i, Zero, Ovf, exp_zero, exp_ovf); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    do_op(8'hF0, 8'h20, 1'b1, 1'b1);
    checks++; if (Result !== 8'h11 || Cout !== 1'b1)
      begin errors++; $display("FAIL pre_rst got %h/%b want 11/1", Result, Cout); end
    @(negedge clk);
    A = 8'h05; B = 8'h05; Cin = 1'b0; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (Result !== 8'h00 || Cout !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL async_rst got %h/%b/%b want 00/0/0", Result, Cout, out_valid); end
    @(posedge clk);
    #1;
    checks++; if (Result !== 8'h00 || out_valid !== 1'b0)
      begin errors++; $display("FAIL rst_discard got %h/%b want 00/0", Result, out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h05, 8'h05, 1'b0, 1'b1);
    checks++; if (Result !== 8'h0A || out_valid !== 1'b1)
      begin errors++; $display("FAIL post_rst got %h/%b want 0a/1", Result, out_valid); end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
